// File: rtl/game_controller.sv
// Snake game lifecycle sequencer: edge-detects buttons/collisions, runs the
// IDLE/RUN/PAUSED/WIN/LOSE state machine and drives score, step, lives and blink.
module game_controller #(
  parameter int STEP_DIV  = 25,
  parameter int BLINK_DIV = 50,
  parameter int MAX_LIVES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic       gameComplete,
  output logic       scoreInc,
  output logic       scoreClr,
  output logic       stepTick,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       dispEnable
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(MAX_LIVES);

  localparam int B_START = 0;
  localparam int B_PAUSE = 1;
  localparam int B_GOOD  = 2;
  localparam int B_BAD   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4
  } state_t;

  logic [3:0] btn_sync_reg;
  logic [3:0] btn_prev_reg;
  logic [3:0] btn_evt;
  logic       game_complete_reg;

  state_t        state_reg, state_next;
  logic [1:0]    lives_reg, lives_next;
  logic [SW-1:0] step_cnt_reg, step_cnt_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          disp_reg, disp_next;
  logic          score_inc_reg, score_inc_next;
  logic          score_clr_reg, score_clr_next;
  logic          step_tick_reg, step_tick_next;
  logic          next_blinks;

  // Sync and history regs reset high so a level held through reset is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync_reg      <= '1;
      btn_prev_reg      <= '1;
      game_complete_reg <= 1'b0;
    end else begin
      btn_sync_reg      <= {badColl, goodColl, pause, start};
      btn_prev_reg      <= btn_sync_reg;
      game_complete_reg <= gameComplete;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
      assign btn_evt[gi] = btn_sync_reg[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      lives_reg     <= LIVES_INIT;
      step_cnt_reg  <= '0;
      blink_cnt_reg <= '0;
      disp_reg      <= 1'b1;
      score_inc_reg <= 1'b0;
      score_clr_reg <= 1'b0;
      step_tick_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lives_reg     <= lives_next;
      step_cnt_reg  <= step_cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      disp_reg      <= disp_next;
      score_inc_reg <= score_inc_next;
      score_clr_reg <= score_clr_next;
      step_tick_reg <= step_tick_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lives_next     = lives_reg;
    step_cnt_next  = step_cnt_reg;
    blink_cnt_next = blink_cnt_reg;
    disp_next      = disp_reg;
    score_inc_next = 1'b0;
    score_clr_next = 1'b0;
    step_tick_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (btn_evt[B_START]) begin
          state_next     = ST_RUN;
          score_clr_next = 1'b1;
          lives_next     = LIVES_INIT;
          step_cnt_next  = '0;
        end
      end
      ST_RUN: begin
        step_tick_next = (step_cnt_reg == STEP_LAST);
        step_cnt_next  = (step_cnt_reg == STEP_LAST) ? '0 : step_cnt_reg + SW'(1);
        if (game_complete_reg) begin
          state_next = ST_WIN;
        end else if (btn_evt[B_BAD]) begin
          if (lives_reg <= 2'd1) begin
            lives_next = 2'd0;
            state_next = ST_LOSE;
          end else begin
            lives_next = lives_reg - 2'd1;
          end
        end else begin
          // Food and pause in the same cycle both take effect.
          score_inc_next = btn_evt[B_GOOD];
          if (btn_evt[B_PAUSE]) state_next = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (btn_evt[B_PAUSE]) state_next = ST_RUN;
      end
      ST_WIN, ST_LOSE: begin
        if (btn_evt[B_START]) begin
          state_next = ST_IDLE;
          lives_next = LIVES_INIT;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Blink restarts from "on" on every entry; steady on in IDLE/RUN.
    next_blinks = (state_next == ST_PAUSED) || (state_next == ST_WIN) ||
                  (state_next == ST_LOSE);
    if (!next_blinks) begin
      disp_next = 1'b1;
    end else if (state_next != state_reg) begin
      blink_cnt_next = '0;
      disp_next      = 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_next = '0;
      disp_next      = ~disp_reg;
    end else begin
      blink_cnt_next = blink_cnt_reg + BW'(1);
    end
  end

  assign scoreInc   = score_inc_reg;
  assign scoreClr   = score_clr_reg;
  assign stepTick   = step_tick_reg;
  assign lives      = lives_reg;
  assign state      = state_reg;
  assign dispEnable = disp_reg;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: hand-computed expectations for lifecycle,
// step timing, lives, blink and reset behaviour.
module tb_game_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic       goodColl;
  logic       badColl;
  logic       gameComplete;
  logic       scoreInc;
  logic       scoreClr;
  logic       stepTick;
  logic [1:0] lives;
  logic [2:0] state;
  logic       dispEnable;

  int total;
  int bad;

  game_controller #(
    .STEP_DIV (25),
    .BLINK_DIV(50),
    .MAX_LIVES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .goodColl    (goodColl),
    .badColl     (badColl),
    .gameComplete(gameComplete),
    .scoreInc    (scoreInc),
    .scoreClr    (scoreClr),
    .stepTick    (stepTick),
    .lives       (lives),
    .state       (state),
    .dispEnable  (dispEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic bad_hit();
    badColl = 1'b1;
    tick();
    badColl = 1'b0;
    tick();
  endtask

  initial begin
    int first;
    int second;
    int cnt;
    int errs;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    goodColl = 1'b0;
    badColl = 1'b0;
    gameComplete = 1'b0;
    repeat (3) tick();

    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_disp", int'(dispEnable), 1);
    check("rst_pulses", int'(scoreInc) + int'(scoreClr) + int'(stepTick), 0);
    reset = 1'b0;
    tick();

    // Start from IDLE; event edge is N, outputs visible after N+1.
    start_pulse();
    check("start_state", int'(state), 1);
    check("start_clr", int'(scoreClr), 1);
    check("start_lives", int'(lives), 3);
    cnt = int'(scoreClr);
    first = -1;
    second = -1;
    for (int i = 2; i <= 60; i++) begin
      tick();
      cnt += int'(scoreClr);
      if (stepTick) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("first_step", first, 26);
    check("second_step", second, 51);
    check("clr_count", cnt, 1);

    // Four short food pulses plus one held level: five increments.
    cnt = 0;
    for (int p = 0; p < 4; p++) begin
      goodColl = 1'b1;
      tick();
      cnt += int'(scoreInc);
      goodColl = 1'b0;
      tick();
      cnt += int'(scoreInc);
    end
    goodColl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cnt += int'(scoreInc);
    end
    goodColl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += int'(scoreInc);
    end
    check("inc_count", cnt, 5);

    bad_hit();
    check("bad1_lives", int'(lives), 2);
    check("bad1_state", int'(state), 1);
    bad_hit();
    check("bad2_lives", int'(lives), 1);
    bad_hit();
    check("bad3_lives", int'(lives), 0);
    check("bad3_state", int'(state), 4);
    check("lose_disp0", int'(dispEnable), 1);

    errs = 0;
    for (int i = 1; i <= 160; i++) begin
      tick();
      if (int'(dispEnable) != (((i / 50) % 2 == 0) ? 1 : 0)) errs++;
      if (i == 49) check("lose_disp49", int'(dispEnable), 1);
      if (i == 50) check("lose_disp50", int'(dispEnable), 0);
      if (i == 100) check("lose_disp100", int'(dispEnable), 1);
    end
    check("lose_blink_errs", errs, 0);

    start_pulse();
    check("lose_to_idle", int'(state), 0);
    check("idle_lives", int'(lives), 3);
    check("idle_no_clr", int'(scoreClr), 0);
    check("idle_disp", int'(dispEnable), 1);

    // Restart; step counter reads 0 right after entry.
    start_pulse();
    check("rerun_state", int'(state), 1);
    check("rerun_clr", int'(scoreClr), 1);

    goodColl = 1'b1;
    badColl = 1'b1;
    tick();
    goodColl = 1'b0;
    badColl = 1'b0;
    tick();
    check("both_lives", int'(lives), 2);
    check("both_no_inc", int'(scoreInc), 0);

    // Counter is 2 here; pause event lands when it reads 10, frozen value is 11.
    repeat (7) tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    tick();
    check("pause_state", int'(state), 2);
    check("pause_disp0", int'(dispEnable), 1);
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 20) goodColl = 1'b1;
      if (i == 21) goodColl = 1'b0;
      tick();
      cnt += int'(stepTick) + int'(scoreInc);
      if (i == 49) check("pause_disp49", int'(dispEnable), 1);
      if (i == 50) check("pause_disp50", int'(dispEnable), 0);
      if (i == 100) check("pause_disp100", int'(dispEnable), 1);
    end
    check("pause_quiet", cnt, 0);
    check("pause_hold_state", int'(state), 2);

    pause = 1'b1;
    tick();
    pause = 1'b0;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) begin
        check("unpause_state", int'(state), 1);
        check("unpause_disp", int'(dispEnable), 1);
      end
      if (stepTick && first < 0) first = i;
    end
    check("unpause_step", first, 15);

    gameComplete = 1'b1;
    badColl = 1'b1;
    tick();
    badColl = 1'b0;
    tick();
    check("win_state", int'(state), 3);
    check("win_lives", int'(lives), 2);
    gameComplete = 1'b0;
    tick();
    check("win_hold", int'(state), 3);
    start_pulse();
    check("win_to_idle", int'(state), 0);
    check("win_idle_lives", int'(lives), 3);

    // Start held through reset must not start a game.
    start = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("held_start_idle", int'(state), 0);
    start = 1'b0;
    repeat (2) tick();
    check("held_release_idle", int'(state), 0);
    check("held_no_clr", int'(scoreClr), 0);

    start_pulse();
    check("run3_state", int'(state), 1);
    bad_hit();
    bad_hit();
    check("run3_lives", int'(lives), 1);
    reset = 1'b1;
    goodColl = 1'b1;
    tick();
    check("midrst_state", int'(state), 0);
    check("midrst_lives", int'(lives), 3);
    check("midrst_pulses", int'(scoreInc) + int'(scoreClr) + int'(stepTick), 0);
    check("midrst_disp", int'(dispEnable), 1);
    reset = 1'b0;
    goodColl = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Lifecycle sequencer for the snake game. It turns raw button and collision levels into one-cycle events and runs the game state machine (idle, run, pause, win, lose). It drives the score tracker with increment/clear pulses, generates the snake movement step tick, tracks remaining lives, and gates the seven-segment blink enable. It sits between the `pb` inputs / collision logic and the score tracker / `ssdec` display path in `top`.

## Interface
- `STEP_DIV`, 25: cycles between `stepTick` pulses in RUN (4 Hz at 100 Hz `clk`); legal range is ≥2.
- `BLINK_DIV`, 50: cycles per `dispEnable` half-period in PAUSED/WIN/LOSE; legal range is ≥2.
- `MAX_LIVES`, 3: lives loaded at reset and on game restart; legal range is 1..3.
- `clk`  in  1  system clock (`hz100`).
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  start/restart button, level.
- `pause`  in  1  pause toggle button, level.
- `goodColl`  in  1  food-collision level.
- `badColl`  in  1  wall/self-collision level.
- `gameComplete`  in  1  win flag from score tracker, level.
- `scoreInc`  out  1  one-cycle score increment pulse.
- `scoreClr`  out  1  one-cycle score clear pulse.
- `stepTick`  out  1  one-cycle snake movement pulse.
- `lives`  out  2  remaining lives.
- `state`  out  3  IDLE=0, RUN=1, PAUSED=2, WIN=3, LOSE=4.
- `dispEnable`  out  1  enable for `ssdec` instances.

## Operation
- Edge detect on `start`, `pause`, `goodColl`, `badColl`:
  - event = in & ~prev, where `prev` is the input registered one cycle.
  - `prev` resets to 1, so an input held through reset produces no event until it is released and pressed again.
  - `gameComplete` is level-sensitive.
- IDLE:
  - `dispEnable`=1; all event inputs are ignored except start.
  - start event -> RUN; `scoreClr`=1 and `lives`=MAX_LIVES; step counter is set to 0.
- RUN, per-cycle priority:
  1. `gameComplete`=1 -> WIN. Collisions and pause are ignored that cycle.
  2. Else, on a badColl event:
     - if `lives`==1: `lives`=0 -> LOSE;
     - otherwise `lives`-1 and stay in RUN.
     - A goodColl or pause event in the same cycle is dropped.
  3. Else, on a goodColl event: `scoreInc`=1. If a pause event occurs in the same cycle, both take effect (pulse, then PAUSED).
  4. Else, on a pause event: -> PAUSED.
- RUN step counter:
  - Counts 0..STEP_DIV-1 and wraps to 0.
  - `stepTick`=1 in the cycle after the counter equals STEP_DIV-1.
  - Pulses every STEP_DIV cycles.
- PAUSED:
  - Step counter is frozen (not cleared); `stepTick`, `scoreInc` and collisions are suppressed.
  - A pause event returns to RUN; the counter resumes from its held value.
  - start events are ignored.
- WIN / LOSE:
  - `dispEnable` blinks; collisions and pause are ignored.
  - A start event -> IDLE with `lives`=MAX_LIVES. No `scoreClr` here; the clear happens at the IDLE->RUN transition.
- Blink counter:
  - Cleared to 0 and `dispEnable`=1 on every entry into PAUSED/WIN/LOSE.
  - `dispEnable` toggles each time the counter reaches BLINK_DIV-1, then the counter wraps.
  - In IDLE and RUN, `dispEnable`=1.
- Widths:
  - Step counter is $clog2(STEP_DIV) bits; blink counter is $clog2(BLINK_DIV) bits.
  - `lives` never underflows below 0 and never exceeds MAX_LIVES.

## Timing
- All outputs are registered.
- Reset values: `state`=IDLE, `lives`=MAX_LIVES, `dispEnable`=1, `scoreInc`=`scoreClr`=`stepTick`=0, counters=0, edge `prev` regs=1.
- Latency is 1 cycle: an input sampled high at edge N (the event cycle) shows its outputs/state after edge N+1.
- `scoreInc`, `scoreClr` and `stepTick` are high for exactly one cycle. A held level never repeats a pulse.
- First `stepTick` after entering RUN from IDLE: STEP_DIV+1 cycles after the start event cycle.
- `reset` asserted in any state returns all registers to their reset values on the next edge, overriding any event in that cycle.

## Test plan
- Reset, release, then pulse `start` for 1 cycle -> `state`=1 and `scoreClr`=1 one cycle later, `lives`=3, first `stepTick` 26 cycles after the event, then every 25 cycles.
- In RUN, pulse `goodColl` 4 times and hold `goodColl` high for 10 cycles -> exactly 5 `scoreInc` pulses.
- In RUN, 3 separate `badColl` events -> `lives` 2, 1, 0, with `state`=4 after the third. `dispEnable` stays 1 for 50 cycles after LOSE entry, then toggles every 50 cycles.
- In RUN, raise `goodColl` and `badColl` edges in the same cycle with `lives`=3 -> `lives`=2, no `scoreInc`. Separately, `gameComplete`=1 together with a `badColl` edge -> `state`=3, `lives` unchanged.
- Pause at step counter 10 and hold for 100 cycles -> no `stepTick`, `goodColl` ignored, `dispEnable` blinks. Unpause -> next `stepTick` 15 cycles after the unpause event.
- Hold `start` high through a reset and release -> stays IDLE. Assert `reset` mid-RUN with `lives`=1 -> IDLE, `lives`=3, all pulses 0.
